// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: 8N1 UART receiver with an oversampling tick and a
// 2-of-3 majority vote taken around the middle of every bit.
`default_nettype none

module uart_rx_oversampler #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TICK_W  = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(OVERSAMPLE / 2 + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   state_t              state, state_nxt;
   logic                sync1, sync2;
   logic [DIV_W-1:0]    div_cnt;
   logic [TICK_W-1:0]   tick_cnt;
   logic [2:0]          bit_cnt;
   logic                samp0, samp1;
   logic [7:0]          shreg;
   logic                tick, at_mid, bit_end, majority;
   logic                load, ferr_nxt, shift_en;

   // Counters sit at zero in IDLE, so sampling phase is measured from the start edge.
   assign tick     = (state != IDLE) && (div_cnt == DIV_LAST);
   assign at_mid   = tick && (tick_cnt == TICK_S2);
   assign bit_end  = tick && (tick_cnt == TICK_LAST);
   assign majority = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);
   assign rx_busy  = (state != IDLE);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      ferr_nxt  = 1'b0;
      shift_en  = 1'b0;
      case (state)
         IDLE: begin
            if (!sync2) state_nxt = START;
         end
         START: begin
            if (at_mid && majority) state_nxt = IDLE;
            else if (bit_end)       state_nxt = DATA;
         end
         DATA: begin
            shift_en = at_mid;
            if (bit_end && (bit_cnt == 3'd7)) state_nxt = STOP;
         end
         STOP: begin
            // Leave at mid stop bit so a following start edge is not missed.
            if (at_mid) begin
               if (majority) begin
                  load      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (sync2) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         state      <= IDLE;
         div_cnt    <= '0;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         samp0      <= 1'b0;
         samp1      <= 1'b0;
         shreg      <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync1      <= rx_in;
         sync2      <= sync1;
         state      <= state_nxt;
         data_valid <= load;
         frame_err  <= ferr_nxt;
         if (load) data <= shreg;
         if (state == IDLE) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
         end else if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            if (state == DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         if (tick && tick_cnt == TICK_S0) samp0 <= sync2;
         if (tick && tick_cnt == TICK_S1) samp1 <= sync2;
         if (shift_en) shreg <= {majority, shreg[7:1]};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_oversampler.sv
// tb_uart_rx_oversampler: directed vectors for the UART receiver at 16 clk/bit.
`default_nettype none

module tb_uart_rx_oversampler;

   localparam int BIT = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic [7:0] data;
   logic       data_valid, frame_err, rx_busy;

   uart_rx_oversampler #(
      .CLK_FREQ  (1_600_000),
      .BAUD_RATE (100_000),
      .OVERSAMPLE(16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .data      (data),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0, valid_cnt = 0, ferr_cnt = 0, busy_cyc = 0, last_valid_cyc = 0;
   int overlap = 0, long_pulse = 0;
   logic [7:0] log_data [0:63];
   logic prev_v = 1'b0, prev_f = 1'b0;

   // Pulse monitor sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (data_valid) begin
         if (valid_cnt < 64) log_data[valid_cnt] = data;
         valid_cnt++;
         last_valid_cyc = cyc;
      end
      if (frame_err) ferr_cnt++;
      if (rx_busy) busy_cyc++;
      if (data_valid && frame_err) overlap++;
      if ((data_valid && prev_v) || (frame_err && prev_f)) long_pulse++;
      prev_v = data_valid;
      prev_f = frame_err;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic hold(input logic v, input int n);
      rx_in = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Glitch inverts the line for one clk near the middle of each data bit.
   task automatic send(input logic [7:0] b, input logic stop, input logic glitch);
      hold(1'b0, BIT);
      for (int i = 0; i < 8; i++) begin
         if (glitch) begin
            hold(b[i], 10);
            hold(!b[i], 1);
            hold(b[i], 5);
         end else begin
            hold(b[i], BIT);
         end
      end
      hold(stop, BIT);
   endtask

   typedef struct {
      logic [7:0] val;
      logic       stop;
      logic       glitch;
      int         low_hold;
      int         exp_valid;
      int         exp_ferr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int v0, f0, b0, s0;
      vecs[0] = '{8'hA5, 1'b1, 1'b0, 0,  1, 0, 8'hA5};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 40, 0, 1, 8'hA5};
      vecs[2] = '{8'h55, 1'b1, 1'b0, 0,  1, 0, 8'h55};
      vecs[3] = '{8'h81, 1'b1, 1'b1, 0,  1, 0, 8'h81};

      @(posedge clk);
      #1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("rst_data", data, 8'h00);
      check("rst_valid", data_valid, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_busy", rx_busy, 0);
      rst = 1'b0;
      hold(1'b1, 10);

      // False start: three low clocks.
      v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cyc;
      hold(1'b0, 3);
      hold(1'b1, 30);
      check("false_start_valid", valid_cnt - v0, 0);
      check("false_start_ferr", ferr_cnt - f0, 0);
      check_range("false_start_busy", busy_cyc - b0, 1, 15);
      check("false_start_data", data, 8'h00);

      for (int i = 0; i < 4; i++) begin
         v0 = valid_cnt; f0 = ferr_cnt; s0 = cyc;
         send(vecs[i].val, vecs[i].stop, vecs[i].glitch);
         if (vecs[i].low_hold > 0) begin
            hold(1'b0, vecs[i].low_hold);
            check("busy_wait_idle", rx_busy, 1);
         end
         hold(1'b1, 20);
         check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
         check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
         check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
         check($sformatf("vec%0d_busy", i), rx_busy, 0);
         if (vecs[i].exp_valid == 1)
            check_range($sformatf("vec%0d_latency", i), last_valid_cyc - s0, 156, 158);
      end

      // Back-to-back frames with no idle gap.
      v0 = valid_cnt;
      send(8'h00, 1'b1, 1'b0);
      send(8'hFF, 1'b1, 1'b0);
      hold(1'b1, 20);
      check("b2b_count", valid_cnt - v0, 2);
      check("b2b_first", log_data[v0], 8'h00);
      check("b2b_second", log_data[v0 + 1], 8'hFF);

      // Reset during bit 4 of 0xF0 (line stays high afterwards).
      v0 = valid_cnt; f0 = ferr_cnt;
      hold(1'b0, BIT + 4 * BIT);
      hold(1'b1, 8);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_data", data, 8'h00);
      check("midrst_valid", data_valid, 0);
      check("midrst_ferr", frame_err, 0);
      check("midrst_busy", rx_busy, 0);
      hold(1'b1, 8 + 3 * BIT + BIT + 20);
      check("midrst_no_valid", valid_cnt - v0, 0);
      check("midrst_no_ferr", ferr_cnt - f0, 0);

      v0 = valid_cnt;
      send(8'h5A, 1'b1, 1'b0);
      hold(1'b1, 20);
      check("post_rst_valid", valid_cnt - v0, 1);
      check("post_rst_data", data, 8'h5A);

      check("pulse_overlap", overlap, 0);
      check("pulse_width", long_pulse, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
